// File: rtl/if_id_stage_if.sv
// if_id_stage_if: bundles the fetch->decode handshake of the IF/ID pipeline register.
// master: fetch/control side (drives stall/flush/irq and the fetch bus, observes decode bus).
// slave : the IF/ID register itself (consumes the fetch bus, drives the decode bus).
interface if_id_stage_if;
  // control from hazard unit / branch logic / interrupt controller
  logic        stall;       // 1 = hold all state
  logic        flush;       // 1 = load a bubble (wins over stall)
  logic        irq;         // level-sensitive external interrupt request

  // fetch-side bus
  logic [31:0] PC_in;       // bit 31 = kernel/supervisor flag
  logic [31:0] PCplus_in;
  logic [31:0] Instr_in;

  // decode-side bus
  logic [31:0] PC_out;
  logic [31:0] PCplus_out;
  logic [31:0] Instr_out;
  logic        valid_out;   // 0 = bubble
  logic        irq_take_out; // 1 = this slot is an injected interrupt

  modport master (
    output stall, flush, irq, PC_in, PCplus_in, Instr_in,
    input  PC_out, PCplus_out, Instr_out, valid_out, irq_take_out
  );

  modport slave (
    input  stall, flush, irq, PC_in, PCplus_in, Instr_in,
    output PC_out, PCplus_out, Instr_out, valid_out, irq_take_out
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with stall, flush and user-mode interrupt injection.
// Latency: 1 cycle fetch -> decode. Edge priority: flush > stall > load.
// Backpressure: stall holds every output and the interrupt state; flush overrides stall.
// Ports: clk, reset (async active-high); bus (if_id_stage_if.slave) carrying
//   stall/flush/irq, PC_in/PCplus_in/Instr_in in, PC_out/PCplus_out/Instr_out/valid_out/
//   irq_take_out out.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter logic [31:0] RESET_PC  = 32'h80000000
) (
  input  logic          clk,
  input  logic          reset,
  if_id_stage_if.slave  bus
);

  localparam logic [31:0] RESET_PCPLUS = RESET_PC + 32'd4;

  // Interrupt tracking:
  //   IDLE    - no request outstanding
  //   PENDING - user-mode request latched, waiting for a load slot to carry it
  //   TAKEN   - slot injected, waiting for fetch to reach kernel space (handler entry)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_TAKEN   = 2'b10
  } irq_state_t;

  irq_state_t  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pcplus;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_irq_take;

  logic w_kernel;   // fetch PC is in kernel space
  logic w_advance;  // this edge updates state (flush beats stall)
  logic w_load;     // ordinary load edge
  logic w_inject;   // load edge that carries the latched interrupt

  assign w_kernel  = bus.PC_in[31];
  assign w_advance = bus.flush | ~bus.stall;
  assign w_load    = ~bus.flush & ~bus.stall;
  // The instruction currently in fetch is not committed; its PC becomes the return address.
  assign w_inject  = w_load & (r_state == ST_PENDING) & ~w_kernel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_pcplus   <= RESET_PCPLUS;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_irq_take <= 1'b0;
    end else if (w_advance) begin
      // PC and PC+4 follow fetch on every advancing edge, bubble or not, so a flushed
      // slot still names the redirect target (used as return address if injected later).
      r_pc     <= bus.PC_in;
      r_pcplus <= bus.PCplus_in;

      if (bus.flush) begin
        r_instr    <= NOP_INSTR;
        r_valid    <= 1'b0;
        r_irq_take <= 1'b0;
      end else if (w_inject) begin
        r_instr    <= NOP_INSTR;
        r_valid    <= 1'b0;
        r_irq_take <= 1'b1;
      end else begin
        r_instr    <= bus.Instr_in;
        r_valid    <= 1'b1;
        r_irq_take <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          // Requests raised while already in kernel space are ignored, not latched.
          if (bus.irq && !w_kernel) r_state <= ST_PENDING;
        end
        ST_PENDING: begin
          // Kernel entered by some other path: the request is considered serviced.
          if (w_kernel)       r_state <= ST_IDLE;
          else if (w_inject)  r_state <= ST_TAKEN;
          // flush edge: keep waiting; the redirect target becomes the return address.
        end
        ST_TAKEN: begin
          // Block re-injection until decode's redirect lands fetch in the handler.
          if (w_kernel) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.PC_out       = r_pc;
  assign bus.PCplus_out   = r_pcplus;
  assign bus.Instr_out    = r_instr;
  assign bus.valid_out    = r_valid;
  assign bus.irq_take_out = r_irq_take;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed + randomized checks of if_id_stage against a behavioural model.
// Latency: n/a (bench). Backpressure: bench drives stall/flush directly.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the edge.
module tb_if_id_stage;

  localparam logic [31:0] NOP  = 32'h00000000;
  localparam logic [31:0] RPC  = 32'h80000000;

  logic clk;
  logic reset;
  if_id_stage_if bus();

  if_id_stage #(.NOP_INSTR(NOP), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: what decode should see, plus two facts about the interrupt story.
  logic [31:0] m_pc, m_pcplus, m_instr;
  logic        m_valid, m_take;
  bit          m_req_waiting;   // a user-mode request has been accepted but not yet delivered
  bit          m_await_handler; // delivered; another delivery forbidden until kernel reached

  task automatic model_reset();
    m_pc = RPC; m_pcplus = RPC + 32'd4; m_instr = NOP;
    m_valid = 1'b0; m_take = 1'b0;
    m_req_waiting = 0; m_await_handler = 0;
  endtask

  // Applied with the input values present at a rising edge.
  task automatic model_edge(input logic st, input logic fl, input logic iq,
                            input logic [31:0] pc, input logic [31:0] pcp,
                            input logic [31:0] ins);
    bit in_kernel;
    bit deliver;
    if (st && !fl) return;            // frozen
    in_kernel = pc[31];
    deliver   = 0;
    if (m_await_handler) begin
      if (in_kernel) m_await_handler = 0;
    end else if (m_req_waiting) begin
      if (in_kernel) m_req_waiting = 0;
      else if (!fl) begin
        deliver = 1; m_req_waiting = 0; m_await_handler = 1;
      end
    end else if (iq && !in_kernel) begin
      m_req_waiting = 1;              // delivery no earlier than the following load
    end
    m_pc = pc; m_pcplus = pcp;
    if (fl)           begin m_instr = NOP; m_valid = 0; m_take = 0; end
    else if (deliver) begin m_instr = NOP; m_valid = 0; m_take = 1; end
    else              begin m_instr = ins; m_valid = 1; m_take = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},    bus.PC_out,               m_pc);
    chk({tag, ".pcp"},   bus.PCplus_out,           m_pcplus);
    chk({tag, ".instr"}, bus.Instr_out,            m_instr);
    chk({tag, ".valid"}, {31'd0, bus.valid_out},   {31'd0, m_valid});
    chk({tag, ".take"},  {31'd0, bus.irq_take_out},{31'd0, m_take});
  endtask

  task automatic drive(input logic st, input logic fl, input logic iq,
                       input logic [31:0] pc, input logic [31:0] ins);
    bus.stall = st; bus.flush = fl; bus.irq = iq;
    bus.PC_in = pc; bus.PCplus_in = pc + 32'd4; bus.Instr_in = ins;
  endtask

  // One rising edge: model sees the inputs at the edge, DUT sampled 1 unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(bus.stall, bus.flush, bus.irq, bus.PC_in, bus.PCplus_in, bus.Instr_in);
    #1;
    chk_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    // ---- power-on reset ----
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    model_reset();
    #7;
    chk_all("por");
    chk("por.pcp_const", bus.PCplus_out, 32'h80000004);
    #1 reset = 1'b0;

    // ---- plain load ----
    drive(0, 0, 0, 32'h00000010, 32'h8C220004);
    step("load");
    chk("load.pc_const",    bus.PC_out,     32'h00000010);
    chk("load.pcp_const",   bus.PCplus_out, 32'h00000014);
    chk("load.instr_const", bus.Instr_out,  32'h8C220004);

    // ---- stall three cycles with changing inputs, then release ----
    drive(1, 0, 0, 32'h00000014, 32'h11111111); step("stall0");
    drive(1, 0, 0, 32'h00000018, 32'h22222222); step("stall1");
    drive(1, 0, 0, 32'h0000001C, 32'h33333333); step("stall2");
    chk("stall.held_instr", bus.Instr_out, 32'h8C220004);
    drive(0, 0, 0, 32'h0000001C, 32'h33333333); step("release");
    chk("release.instr_const", bus.Instr_out, 32'h33333333);

    // ---- flush and stall together: flush wins ----
    drive(1, 1, 0, 32'h00000040, 32'h44444444); step("flush_stall");
    chk("flush.valid_const", {31'd0, bus.valid_out}, 32'd0);

    // ---- user-mode interrupt: latch, inject, handler entry, no re-inject ----
    drive(0, 0, 1, 32'h00000020, 32'h55555555); step("irq_latch");
    chk("irq_latch.take_const", {31'd0, bus.irq_take_out}, 32'd0);
    drive(0, 0, 0, 32'h00000024, 32'h66666666); step("irq_inject");
    chk("irq_inject.take_const", {31'd0, bus.irq_take_out}, 32'd1);
    chk("irq_inject.pc_const",   bus.PC_out, 32'h00000024);
    drive(0, 0, 0, 32'h80000008, 32'h77777777); step("irq_kernel");
    drive(0, 0, 0, 32'h00000028, 32'h88888888); step("irq_noreinject");
    chk("irq_noreinject.take_const", {31'd0, bus.irq_take_out}, 32'd0);

    // ---- pending survives a flush; stall holds the injected pulse ----
    drive(0, 0, 1, 32'h00000030, 32'h99999999); step("pend_latch");
    drive(0, 1, 0, 32'h00000200, 32'hAAAAAAAA); step("pend_flush");
    drive(0, 0, 0, 32'h00000200, 32'hBBBBBBBB); step("pend_inject");
    drive(1, 0, 0, 32'h00000204, 32'hCCCCCCCC); step("pend_hold");
    chk("pend_hold.take_const", {31'd0, bus.irq_take_out}, 32'd1);
    drive(0, 0, 0, 32'h80000180, 32'hDDDDDDDD); step("pend_handler");

    // ---- kernel-mode irq held five cycles: ignored ----
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'h80000100 + 32'(4 * i), 32'h01000000 + 32'(i));
      step("kirq");
      chk("kirq.take_const", {31'd0, bus.irq_take_out}, 32'd0);
    end

    // ---- pending cancelled by kernel entry ----
    drive(0, 0, 1, 32'h00000300, 32'h12121212); step("cancel_latch");
    drive(0, 0, 0, 32'h80000000, 32'h34343434); step("cancel_kernel");
    drive(0, 0, 0, 32'h00000304, 32'h56565656); step("cancel_user");

    // ---- asynchronous reset mid-stall with a request pending ----
    drive(0, 0, 1, 32'h00000400, 32'h78787878); step("rst_pre");
    drive(1, 0, 0, 32'h00000404, 32'h9A9A9A9A);
    #2 reset = 1'b1;
    model_reset();
    #1 chk_all("rst_async");
    step("rst_edge");
    chk("rst_edge.pc_const", bus.PC_out, 32'h80000000);
    #3 reset = 1'b0;
    drive(0, 0, 0, 32'h00000408, 32'hBCBCBCBC); step("rst_after");

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
      rpc[31] = ($urandom_range(0, 9) < 3);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 4) == 0), rpc, $urandom);
      if ($urandom_range(0, 3) == 0) bus.PCplus_in = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
